// File: rtl/uart_arb_pkg.sv
// Shared constants and helpers for the two-client UART transmit arbiter.
package uart_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic CL_A = 1'b0;
   localparam logic CL_B = 1'b1;

   localparam logic [15:0] TIMEOUT_CYCLES_DEF = 16'd50000;

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       lock;
   } client_req_t;

   // Grant vector is {B,A}, so client id maps directly onto a one-hot bit.
   function automatic logic [1:0] client_onehot(input logic id);
      return (id == CL_B) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of client handshakes and the UART core handshake seen by the arbiter.
interface uart_tx_arbiter_if;

   logic       a_valid;
   logic [7:0] a_data;
   logic       a_lock;
   logic       a_ready;

   logic       b_valid;
   logic [7:0] b_data;
   logic       b_lock;
   logic       b_ready;

   logic [7:0] uart_txdata;
   logic       uart_txbegin;
   logic       uart_txbusy;

   logic [1:0] grant;
   logic       lock_to;

   modport slave (
      input  a_valid, a_data, a_lock,
      input  b_valid, b_data, b_lock,
      input  uart_txbusy,
      output a_ready, b_ready,
      output uart_txdata, uart_txbegin,
      output grant, lock_to
   );

   modport master (
      output a_valid, a_data, a_lock,
      output b_valid, b_data, b_lock,
      output uart_txbusy,
      input  a_ready, b_ready,
      input  uart_txdata, uart_txbegin,
      input  grant, lock_to
   );

endinterface

// File: rtl/uart_arb_rr_pick.sv
// Combinational winner selection: lock owner only when locked, else round-robin on a tie.
module uart_arb_rr_pick
   import uart_arb_pkg::*;
(
   input  logic a_valid_i,
   input  logic b_valid_i,
   input  logic rr_next_i,
   input  logic lock_valid_i,
   input  logic lock_owner_i,
   output logic win_valid_o,
   output logic win_id_o
);

   // A locked owner excludes the other client even when the owner has nothing to send.
   always_comb begin
      win_valid_o = 1'b0;
      win_id_o    = CL_A;
      if (lock_valid_i) begin
         win_id_o    = lock_owner_i;
         win_valid_o = (lock_owner_i == CL_B) ? b_valid_i : a_valid_i;
      end else if (a_valid_i && b_valid_i) begin
         win_valid_o = 1'b1;
         win_id_o    = rr_next_i;
      end else if (a_valid_i) begin
         win_valid_o = 1'b1;
         win_id_o    = CL_A;
      end else if (b_valid_i) begin
         win_valid_o = 1'b1;
         win_id_o    = CL_B;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte clients with round-robin and packet locks.
// Define UART_ARB_LOCK_TIMEOUT_EN to build the stale-lock timeout (drives lock_to).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned        TO_W           = 16,
   parameter logic [TO_W-1:0]    TIMEOUT_CYCLES = TO_W'(TIMEOUT_CYCLES_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave bus
);

   logic [1:0] state_q, state_d;
   logic       rr_next_q, rr_next_d;
   logic       lock_valid_q, lock_valid_d;
   logic       lock_owner_q, lock_owner_d;
   logic [7:0] txdata_q, txdata_d;
   logic       txbegin_q, txbegin_d;
   logic       a_ready_q, a_ready_d;
   logic       b_ready_q, b_ready_d;
   logic [1:0] grant_q, grant_d;

   logic       in_idle;
   logic       owner_lock;
   logic       lock_release;
   logic       lock_eff;
   logic       win_valid;
   logic       win_id;
   logic       win_lock;
   logic [7:0] win_data;
   logic       can_grant;
   logic       to_fire;

   assign in_idle      = (state_q == ST_IDLE);
   assign owner_lock   = (lock_owner_q == CL_B) ? bus.b_lock : bus.a_lock;
   assign lock_release = in_idle && lock_valid_q && !owner_lock;
   // Release is seen by the picker in the same cycle so the other client can win immediately.
   assign lock_eff     = lock_valid_q && !lock_release;

   uart_arb_rr_pick u_pick (
      .a_valid_i    (bus.a_valid),
      .b_valid_i    (bus.b_valid),
      .rr_next_i    (rr_next_q),
      .lock_valid_i (lock_eff),
      .lock_owner_i (lock_owner_q),
      .win_valid_o  (win_valid),
      .win_id_o     (win_id)
   );

   assign win_lock  = (win_id == CL_B) ? bus.b_lock : bus.a_lock;
   assign win_data  = (win_id == CL_B) ? bus.b_data : bus.a_data;
   assign can_grant = in_idle && !bus.uart_txbusy && win_valid;

`ifdef UART_ARB_LOCK_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            owner_valid;
   logic            lock_to_q;

   assign owner_valid = (lock_owner_q == CL_B) ? bus.b_valid : bus.a_valid;

   // Count idle cycles where a lock is held by a client with nothing to send.
   always_comb begin
      to_cnt_d = to_cnt_q;
      to_fire  = 1'b0;
      if (can_grant || lock_release) begin
         to_cnt_d = '0;
      end else if (in_idle && lock_valid_q && !owner_valid) begin
         if (to_cnt_q + TO_ONE == TIMEOUT_CYCLES) begin
            to_cnt_d = '0;
            to_fire  = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q  <= '0;
         lock_to_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         lock_to_q <= to_fire;
      end
   end

   assign bus.lock_to = lock_to_q;
`else
   assign to_fire     = 1'b0;
   assign bus.lock_to = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      rr_next_d    = rr_next_q;
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      txdata_d     = txdata_q;
      txbegin_d    = txbegin_q;
      grant_d      = grant_q;
      a_ready_d    = 1'b0;
      b_ready_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (lock_release || to_fire) begin
               lock_valid_d = 1'b0;
            end
            if (can_grant) begin
               txdata_d  = win_data;
               a_ready_d = (win_id == CL_A);
               b_ready_d = (win_id == CL_B);
               grant_d   = client_onehot(win_id);
               rr_next_d = ~win_id;
               txbegin_d = 1'b1;
               state_d   = ST_START;
               if (win_lock) begin
                  lock_valid_d = 1'b1;
                  lock_owner_d = win_id;
               end
            end
         end
         ST_START: begin
            // The UART latches txdata once it reports busy; only then drop the request.
            if (bus.uart_txbusy) begin
               txbegin_d = 1'b0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!bus.uart_txbusy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            txbegin_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_next_q    <= CL_A;
         lock_valid_q <= 1'b0;
         lock_owner_q <= CL_A;
         txdata_q     <= 8'h00;
         txbegin_q    <= 1'b0;
         a_ready_q    <= 1'b0;
         b_ready_q    <= 1'b0;
         grant_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         rr_next_q    <= rr_next_d;
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
         txdata_q     <= txdata_d;
         txbegin_q    <= txbegin_d;
         a_ready_q    <= a_ready_d;
         b_ready_q    <= b_ready_d;
         grant_q      <= grant_d;
      end
   end

   assign bus.uart_txdata  = txdata_q;
   assign bus.uart_txbegin = txbegin_q;
   assign bus.a_ready      = a_ready_q;
   assign bus.b_ready      = b_ready_q;
   assign bus.grant        = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed client streams, a simple UART busy model,
// and a monitor that checks every byte handed to the UART against the expected order.
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   typedef struct packed {
      logic [1:0] grant;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic forceBusy = 1'b0;
   logic modelBusy = 1'b0;
   int   modelCnt = 0;

   int   errors = 0;
   int   checks = 0;
   exp_t expQ[$];

   uart_tx_arbiter_if bus();

   uart_tx_arbiter #(
      .TO_W           (16),
      .TIMEOUT_CYCLES (16'd20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.uart_txbusy = modelBusy | forceBusy;

   // UART core model: notices txbegin, goes busy a couple of cycles later, then idles again.
   always @(posedge clk) begin
      if (modelCnt == 0) begin
         if (bus.uart_txbegin) modelCnt <= 1;
      end else if (modelCnt < 8) begin
         modelCnt <= modelCnt + 1;
      end else begin
         modelCnt <= 0;
      end
      modelBusy <= (modelCnt >= 2) && (modelCnt < 8);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present one byte from a client, wait for its ready pulse, then retire it.
   task automatic applyStimulus(input bit isB, input logic [7:0] data, input bit lockDuring,
                                input bit lockAfter, output int latency);
      bit seen;
      seen = 1'b0;
      latency = 0;
      if (isB) begin
         bus.b_valid = 1'b1; bus.b_data = data; bus.b_lock = lockDuring;
      end else begin
         bus.a_valid = 1'b1; bus.a_data = data; bus.a_lock = lockDuring;
      end
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         latency++;
         if (isB ? bus.b_ready : bus.a_ready) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL readyTimeout: client %0d byte %0h never accepted", isB, data);
      end
      if (isB) begin
         bus.b_valid = 1'b0; bus.b_lock = lockAfter;
      end else begin
         bus.a_valid = 1'b0; bus.a_lock = lockAfter;
      end
   endtask

   // Monitor: sample 1 time unit after each rising edge and score every new txbegin.
   initial begin : monitor
      logic prevBegin;
      logic prevBusy;
      exp_t e;
      prevBegin = 1'b0;
      prevBusy  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (bus.uart_txbegin && !prevBegin) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpectedGrant: data %0h grant %0b with nothing expected",
                           bus.uart_txdata, bus.grant);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("txdata", {24'd0, bus.uart_txdata}, {24'd0, e.data});
                  checkOutput("grant", {30'd0, bus.grant}, {30'd0, e.grant});
               end
            end
            if (prevBegin) checkOutput("txbeginHold", {31'd0, bus.uart_txbegin}, {31'd0, !prevBusy});
            if (bus.a_ready || bus.b_ready) begin
               checkOutput("readyExclusive", {31'd0, bus.a_ready & bus.b_ready}, 32'd0);
               checkOutput("readyWithBegin", {30'd0, bus.uart_txbegin, !prevBegin}, 32'd3);
               checkOutput("readyGrant", {30'd0, bus.grant}, {30'd0, bus.b_ready, bus.a_ready});
            end
`ifndef UART_ARB_LOCK_TIMEOUT_EN
            checkOutput("lockToTied", {31'd0, bus.lock_to}, 32'd0);
`endif
         end
         prevBegin = rst_n ? bus.uart_txbegin : 1'b0;
         prevBusy  = bus.uart_txbusy;
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int lat;
      int latB;
      int bSeen;
      bit found;

      bus.a_valid = 1'b0; bus.a_data = 8'h00; bus.a_lock = 1'b0;
      bus.b_valid = 1'b0; bus.b_data = 8'h00; bus.b_lock = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("resetGrant", {30'd0, bus.grant}, 32'd0);
      checkOutput("resetTxbegin", {31'd0, bus.uart_txbegin}, 32'd0);
      checkOutput("resetTxdata", {24'd0, bus.uart_txdata}, 32'd0);
      checkOutput("resetReady", {30'd0, bus.b_ready, bus.a_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] A only");
      expQ.push_back('{2'b01, 8'h41});
      applyStimulus(1'b0, 8'h41, 1'b0, 1'b0, lat);
      checkOutput("aOnlyLatency", lat, 32'd1);
      repeat (12) @(negedge clk);
      checkOutput("aOnlyGrantHeld", {30'd0, bus.grant}, 32'd1);
      checkOutput("aOnlyTxdataHeld", {24'd0, bus.uart_txdata}, 32'h41);

      $display("[TB] B only");
      expQ.push_back('{2'b10, 8'h42});
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, lat);
      checkOutput("bOnlyLatency", lat, 32'd1);
      repeat (12) @(negedge clk);
      checkOutput("bOnlyGrantHeld", {30'd0, bus.grant}, 32'd2);

      $display("[TB] tie round robin");
      expQ.push_back('{2'b01, 8'h11});
      expQ.push_back('{2'b10, 8'h33});
      expQ.push_back('{2'b01, 8'h22});
      expQ.push_back('{2'b10, 8'h44});
      fork
         begin
            applyStimulus(1'b0, 8'h11, 1'b0, 1'b0, lat);
            applyStimulus(1'b0, 8'h22, 1'b0, 1'b0, lat);
         end
         begin
            applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, latB);
            applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, latB);
         end
      join
      repeat (12) @(negedge clk);
      checkOutput("tieDrained", expQ.size(), 32'd0);

      $display("[TB] B packet lock");
      expQ.push_back('{2'b10, 8'hB1});
      expQ.push_back('{2'b10, 8'hB2});
      expQ.push_back('{2'b10, 8'hB3});
      expQ.push_back('{2'b01, 8'hA1});
      fork
         begin
            applyStimulus(1'b1, 8'hB1, 1'b1, 1'b1, latB);
            applyStimulus(1'b1, 8'hB2, 1'b1, 1'b1, latB);
            applyStimulus(1'b1, 8'hB3, 1'b1, 1'b0, latB);
         end
         begin
            found = 1'b0;
            for (int i = 0; i < 50 && !found; i++) begin
               @(negedge clk);
               if (bus.b_ready) found = 1'b1;
            end
            checkOutput("lockFirstB", {31'd0, found}, 32'd1);
            applyStimulus(1'b0, 8'hA1, 1'b0, 1'b0, lat);
         end
      join
      repeat (12) @(negedge clk);
      checkOutput("lockDrained", expQ.size(), 32'd0);

      $display("[TB] busy gating");
      forceBusy = 1'b1;
      repeat (2) @(negedge clk);
      expQ.push_back('{2'b01, 8'h5A});
      fork
         applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0, lat);
         begin
            repeat (10) @(negedge clk);
            forceBusy = 1'b0;
         end
      join
      checkOutput("busyGateLatency", lat, 32'd11);
      repeat (12) @(negedge clk);

      $display("[TB] reset mid START");
      expQ.push_back('{2'b01, 8'h77});
      applyStimulus(1'b0, 8'h77, 1'b0, 1'b0, lat);
      checkOutput("beginBeforeReset", {31'd0, bus.uart_txbegin}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("resetDropsBegin", {31'd0, bus.uart_txbegin}, 32'd0);
      checkOutput("resetClearsGrant", {30'd0, bus.grant}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expQ.push_back('{2'b01, 8'h81});
      expQ.push_back('{2'b10, 8'h82});
      fork
         applyStimulus(1'b0, 8'h81, 1'b0, 1'b0, lat);
         applyStimulus(1'b1, 8'h82, 1'b0, 1'b0, latB);
      join
      repeat (12) @(negedge clk);
      checkOutput("resetDrained", expQ.size(), 32'd0);

      $display("[TB] stale lock");
      expQ.push_back('{2'b01, 8'hC1});
      applyStimulus(1'b0, 8'hC1, 1'b1, 1'b1, lat);
      expQ.push_back('{2'b10, 8'hD1});
      fork
         applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0, latB);
         begin
`ifdef UART_ARB_LOCK_TIMEOUT_EN
            found = 1'b0;
            bSeen = 0;
            for (int i = 0; i < 100 && !found; i++) begin
               @(negedge clk);
               if (bus.lock_to) found = 1'b1;
               if (bus.b_ready) bSeen++;
            end
            checkOutput("lockToSeen", {31'd0, found}, 32'd1);
            checkOutput("bHeldBeforeTimeout", bSeen, 32'd0);
            @(negedge clk);
            checkOutput("bGrantAfterTimeout", {31'd0, bus.b_ready}, 32'd1);
            bus.a_lock = 1'b0;
`else
            bSeen = 0;
            repeat (60) begin
               @(negedge clk);
               if (bus.b_ready) bSeen++;
            end
            checkOutput("bHeldByLock", bSeen, 32'd0);
            bus.a_lock = 1'b0;
            @(negedge clk);
            checkOutput("bGrantOnRelease", {31'd0, bus.b_ready}, 32'd1);
`endif
         end
      join
      repeat (12) @(negedge clk);
      checkOutput("staleDrained", expQ.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
